// File: rtl/pe_sys_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_sys_pkg
// Description : Shared FSM state type and accumulator saturation limits for
//               the systolic PE accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package pe_sys_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    localparam int c_LIM_W = 64;

    // Upper clamp bound for an m-bit accumulator (m <= 64)
    function automatic logic [c_LIM_W-1:0] sat_hi(input int m, input logic sn);
        logic [c_LIM_W-1:0] r;
        if (sn)
            r = (64'd1 << (m - 1)) - 64'd1;
        else if (m >= c_LIM_W)
            r = '1;
        else
            r = (64'd1 << m) - 64'd1;
        return r;
    endfunction

    // Lower clamp bound; truncated to m bits the signed case is -2^(m-1)
    function automatic logic [c_LIM_W-1:0] sat_lo(input int m, input logic sn);
        return sn ? (64'd1 << (m - 1)) : 64'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_sys_acc_if.sv
`default_nettype none
// ============================================================================
// Module      : pe_sys_acc_if
// Description : Operand/tag stream between neighbouring PEs.
// Revision    : 1.0 - initial release
// ============================================================================
interface pe_sys_acc_if #(
    parameter int N = 8
) ();
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         valid;
    logic         first;
    logic         last;

    modport master (output a, b, valid, first, last);
    modport slave  (input  a, b, valid, first, last);
endinterface
`default_nettype wire

// File: rtl/pe_sys_mac.sv
`default_nettype none
// ============================================================================
// Module      : pe_sys_mac
// Description : Combinational multiply / extend / accumulate datapath.
//               PE_SYS_ACC_SAT_EN selects saturating instead of wrapping adds.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_sys_mac
    import pe_sys_pkg::*;
#(
    parameter int N = 8,
    parameter int M = 24
) (
    input  wire logic [N-1:0] i_a,
    input  wire logic [N-1:0] i_b,
    input  wire logic         i_sn,
    input  wire logic         i_load,
    input  wire logic [M-1:0] i_acc,
    output logic      [M-1:0] o_acc_nxt,
    output logic              o_clamp
);

    logic [2*N-1:0] w_a_ext;
    logic [2*N-1:0] w_b_ext;
    logic [2*N-1:0] w_prod;
    logic [M-1:0]   w_prod_m;
    logic [M:0]     w_sum;

    // Low 2N bits of a 2N x 2N product are correct for both signednesses
    assign w_a_ext  = {{N{i_sn & i_a[N-1]}}, i_a};
    assign w_b_ext  = {{N{i_sn & i_b[N-1]}}, i_b};
    assign w_prod   = w_a_ext * w_b_ext;
    assign w_prod_m = {{(M-2*N){i_sn & w_prod[2*N-1]}}, w_prod};
    assign w_sum    = {i_sn & i_acc[M-1], i_acc} + {i_sn & w_prod_m[M-1], w_prod_m};

`ifdef PE_SYS_ACC_SAT_EN
    logic [M-1:0] w_hi;
    logic [M-1:0] w_lo;
    logic         w_ovf;

    assign w_hi  = M'(sat_hi(M, i_sn));
    assign w_lo  = M'(sat_lo(M, i_sn));
    // A loaded product always fits, so only running additions can clamp
    assign w_ovf = !i_load & (i_sn ? (w_sum[M] ^ w_sum[M-1]) : w_sum[M]);

    assign o_acc_nxt = i_load ? w_prod_m
                     : w_ovf  ? ((i_sn & w_sum[M]) ? w_lo : w_hi)
                     : w_sum[M-1:0];
    assign o_clamp   = w_ovf;
`else
    logic w_unused_carry;
    assign w_unused_carry = w_sum[M];

    assign o_acc_nxt = i_load ? w_prod_m : w_sum[M-1:0];
    assign o_clamp   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/pe_sys_acc.sv
`default_nettype none
// ============================================================================
// Module      : pe_sys_acc
// Description : Systolic PE: operand forwarding, dot-product accumulator,
//               result register and column drain. Macro PE_SYS_ACC_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_sys_acc
    import pe_sys_pkg::*;
#(
    parameter int N = 8,
    parameter int M = 24
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    pe_sys_acc_if.slave       s_in,
    pe_sys_acc_if.master      m_fwd,
    input  wire logic         i_sn,
    input  wire logic         i_drain_shift,
    input  wire logic [M-1:0] i_drain_in,
    input  wire logic         i_drain_vin,
    output logic      [M-1:0] o_drain_out,
    output logic              o_drain_vout,
    output logic      [M-1:0] o_acc_out,
    output logic              o_busy,
    output logic              o_ovf,
    output logic              o_sat
);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [M-1:0]   r_acc;
    logic [M-1:0]   r_res;
    logic           r_res_vld;
    logic [M-1:0]   r_drain;
    logic           r_drain_v;
    logic           r_ovf;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic           r_v;
    logic           r_f;
    logic           r_l;

    logic           w_upd;
    logic           w_res_wr;
    logic           w_drain_ld;
    logic           w_clamp;
    logic [M-1:0]   w_acc_nxt;

    pe_sys_mac #(.N(N), .M(M)) u_mac (
        .i_a       (s_in.a),
        .i_b       (s_in.b),
        .i_sn      (i_sn),
        .i_load    (s_in.first),
        .i_acc     (r_acc),
        .o_acc_nxt (w_acc_nxt),
        .o_clamp   (w_clamp)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_upd       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_upd = s_in.valid & s_in.first;
                if (s_in.valid & s_in.first & !s_in.last)
                    w_state_nxt = ST_ACC;
            end
            ST_ACC: begin
                w_upd = s_in.valid;
                if (s_in.valid & s_in.last)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_res_wr   = w_upd & s_in.last;
    assign w_drain_ld = !i_drain_shift & r_res_vld & !r_drain_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0;
            r_b <= '0;
            r_v <= 1'b0;
            r_f <= 1'b0;
            r_l <= 1'b0;
        end else begin
            r_a <= s_in.a;
            r_b <= s_in.b;
            r_v <= s_in.valid;
            r_f <= s_in.first;
            r_l <= s_in.last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_res     <= '0;
            r_res_vld <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_upd)
                r_acc <= w_acc_nxt;
            // A same-cycle drain load frees the slot, so that write is not an overrun
            if (w_res_wr) begin
                r_res     <= w_acc_nxt;
                r_res_vld <= 1'b1;
                if (r_res_vld & !w_drain_ld)
                    r_ovf <= 1'b1;
            end else if (w_drain_ld) begin
                r_res_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drain   <= '0;
            r_drain_v <= 1'b0;
        end else if (i_drain_shift) begin
            r_drain   <= i_drain_in;
            r_drain_v <= i_drain_vin;
        end else if (w_drain_ld) begin
            r_drain   <= r_res;
            r_drain_v <= 1'b1;
        end
    end

`ifdef PE_SYS_ACC_SAT_EN
    logic r_sat;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sat <= 1'b0;
        else if (w_upd & w_clamp)
            r_sat <= 1'b1;
    end
    assign o_sat = r_sat;
`else
    logic w_unused_clamp;
    assign w_unused_clamp = w_clamp;
    assign o_sat = 1'b0;
`endif

    assign m_fwd.a      = r_a;
    assign m_fwd.b      = r_b;
    assign m_fwd.valid  = r_v;
    assign m_fwd.first  = r_f;
    assign m_fwd.last   = r_l;
    assign o_drain_out  = r_drain;
    assign o_drain_vout = r_drain_v;
    assign o_acc_out    = r_acc;
    assign o_busy       = (r_state == ST_ACC);
    assign o_ovf        = r_ovf;

endmodule
`default_nettype wire

// File: doc/pe_sys_acc.md
PE_SYS_ACC -- requirements
Module: pe_sys_acc

Interface
REQ-001 Parameter N, default 8: operand width.
REQ-002 Parameter M, default 24: accumulator/result width; M >= 2N+1.
REQ-003 clk  in  1  clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 a_in, b_in  in  N  operands.
REQ-006 valid_in, first_in, last_in  in  1  operand-valid, first-term-of-dot-product, last-term.
REQ-007 sn  in  1  1 = signed operands, 0 = unsigned; sampled per valid term.
REQ-008 a_out, b_out  out  N  registered operand forwarding.
REQ-009 valid_out, first_out, last_out  out  1  registered tag forwarding.
REQ-010 drain_shift  in  1  column drain-shift command.
REQ-011 drain_in  in  M; drain_vin  in  1  upstream drain data/valid.
REQ-012 drain_out  out  M; drain_vout  out  1  drain register data/valid.
REQ-013 acc_out  out  M  live accumulator; busy  out  1  state==ACC.
REQ-014 ovf  out  1  sticky result-overrun flag; sat  out  1  sticky saturation flag.

Function
REQ-015 a_in, b_in, valid_in, first_in and last_in SHALL appear on the matching *_out ports exactly 1 cycle later, unconditionally.
REQ-016 Product SHALL be 2N bits, signed multiply when sn=1, unsigned when sn=0; extended to M bits by sign-extension (sn=1) or zero-extension (sn=0).
REQ-017 FSM states IDLE, ACC: IDLE --valid&first&!last--> ACC; ACC --valid&last--> IDLE; all other cases hold.
REQ-018 valid&first (any state) SHALL load acc with the product, discarding any partial sum; otherwise valid in ACC SHALL add the product to acc.
REQ-019 valid without first in IDLE SHALL be ignored for accumulation (still forwarded).
REQ-020 valid&last SHALL write the final sum (including that term) into result register res and set res_vld the next cycle; valid&first&last SHALL yield a single-term result and stay in IDLE.
REQ-021 Drain register priority per cycle: drain_shift=1 -> drain_out<=drain_in, drain_vout<=drain_vin; else if res_vld & !drain_vout -> drain_out<=res, drain_vout<=1, res_vld<=0; else hold.
REQ-022 A new res write while res_vld=1 SHALL overwrite res and set ovf (sticky until reset).
REQ-023 A res write and a res->drain load in the same cycle SHALL keep res_vld=1 holding the new value and SHALL NOT set ovf.
REQ-024 Without saturation, accumulation SHALL wrap modulo 2^M.

Reset
REQ-025 rst low SHALL asynchronously clear all registers: state IDLE, acc, res, res_vld, drain_out, drain_vout, all forwarded outputs, ovf, sat = 0.
REQ-026 rst asserted mid-dot-product SHALL discard the partial sum; the next dot product SHALL require first_in.

Configuration
REQ-027 Macro PE_SYS_ACC_SAT_EN defined: acc updates SHALL clamp to [-2^(M-1), 2^(M-1)-1] when sn=1, or [0, 2^M-1] when sn=0, and set sat (sticky) on any clamp.
REQ-028 Macro undefined: wrap per REQ-024; sat SHALL be tied 0.

Structure
REQ-029 Package pe_sys_pkg SHALL hold the FSM state enum and the saturation-limit helper functions.
REQ-030 The multiply/extend/add datapath SHALL be one sub-module, pe_sys_mac (combinational, parameters N, M); FSM, forwarding and drain logic remain in pe_sys_acc.

Verification (N=8, M=24 unless stated)
REQ-031 sn=1, terms (-3,5)first, (7,-2), (127,127)last -> res=16100 (0x003EE4); drain_out=16100, drain_vout=1 two cycles after last, drain_shift=0.
REQ-032 sn=0, single term (255,255) with first&last -> drain_out=65025, state stays IDLE, busy never 1.
REQ-033 a_in=0x5A, valid_in=1 at cycle t -> a_out=0x5A, valid_out=1 at t+1; all forwarded outputs 0 during reset.
REQ-034 drain_vout=1 and res_vld=1; drain_shift=1 one cycle with drain_in=0x000123, drain_vin=1 -> drain_out=0x000123; next cycle with drain_shift=0 -> drain_out=local res.
REQ-035 Two complete dot products with drain_vout held 1 (no shift) -> ovf=1, res = second sum; rst pulse mid-ACC -> acc_out=0, busy=0, ovf=0.
REQ-036 M=18, sn=1, nine terms (127,127) -> with PE_SYS_ACC_SAT_EN res=131071, sat=1; without macro res=-116983, sat=0.
